// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the execute-stage multiply/divide unit.
// Contents:
//   WIDTH       - default datapath width
//   F7_MULDIV   - funct7 value that selects the RV32M group
//   md_op       - multiply/divide operation, encoded as funct3
//   md_state    - multiply/divide unit FSM state
package cpu_pkg;

   localparam int WIDTH = 32;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_DONE = 2'd2
   } md_state;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the multiply/divide unit.
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high; valid, once raised, is not withdrawn by the producer until
// the transfer, and the payload is held stable while valid is high and
// ready is low. flush is a sideband abort, not part of either handshake.
// Signals:
//   in_valid/in_ready/in_op/in_a/in_b - operation request
//   flush                             - abort the in-flight operation
//   out_valid/out_ready/out_data      - result response
// Modports: master = core side, slave = unit side.
interface muldiv_unit_if #(parameter int WIDTH = cpu_pkg::WIDTH);
   import cpu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   md_op             in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_op, in_a, in_b, flush, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, flush, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit.
// An unsigned shift-add multiplier / restoring divider works on operand
// magnitudes, one bit per clock, and the sign is fixed up on the last step.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   bus       - muldiv_unit_if.slave (request, flush, response)
//   dbg_state - current FSM state, for observation only
// Parameters:
//   WIDTH - operand/result width, must be >= 4 and even
// Optional build macro MULDIV_EARLY_OUT_EN: divide by zero, signed overflow
// and multiply by zero finish after two edges instead of WIDTH. Results
// are the same either way.
module muldiv_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH = cpu_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   muldiv_unit_if.slave     bus,
   output md_state          dbg_state
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   md_state            state, state_nxt;
   md_op               op_q;
   logic [CNT_W-1:0]   cnt;
   // Multiply: {partial product high, multiplier shifting out}.
   // Divide:   {partial remainder, dividend shifting out / quotient in}.
   logic [2*WIDTH-1:0] acc, acc_step;
   logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   a_raw;    // original rs1, needed by special results
   logic               neg_q;    // product / quotient sign
   logic               neg_r;    // remainder sign (follows dividend)
   logic               div_zero, sovf, mul_zero;
   logic [WIDTH-1:0]   out_data_q, result_c;

   logic               a_signed, b_signed, a_neg, b_neg, in_is_div;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               accept, last_step;

   // ---------------- request decode ----------------
   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (bus.in_op)
         MD_MULH, MD_DIV, MD_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         MD_MULHSU: a_signed = 1'b1;
         default: ;  // MUL low half is the same signed or unsigned
      endcase
      a_neg     = a_signed & bus.in_a[WIDTH-1];
      b_neg     = b_signed & bus.in_b[WIDTH-1];
      a_mag     = a_neg ? -bus.in_a : bus.in_a;
      b_mag     = b_neg ? -bus.in_b : bus.in_b;
      in_is_div = bus.in_op[2];
   end

   assign accept = (state == MD_IDLE) & bus.in_valid & ~bus.flush;

   // ---------------- one radix-2 step ----------------
   logic [WIDTH:0] sum, shifted, diff;
   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff     = shifted - {1'b0, opnd};
      acc_step = '0;
      if (op_q[2]) begin
         // No borrow means the trial subtraction fits: keep it, quotient bit 1.
         if (!diff[WIDTH]) acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else              acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_step = {sum, acc[WIDTH-1:1]};
      end
   end

   // ---------------- sign fix and result select ----------------
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo, rem;
   always_comb begin
      prod_fix = neg_q ? -acc_step : acc_step;
      quo      = acc_step[WIDTH-1:0];
      rem      = acc_step[2*WIDTH-1:WIDTH];
      result_c = '0;
      case (op_q)
         MD_MULH, MD_MULHSU, MD_MULHU:
            result_c = mul_zero ? '0 : prod_fix[2*WIDTH-1:WIDTH];
         MD_DIV, MD_DIVU:
            result_c = div_zero ? '1 : sovf ? a_raw : (neg_q ? -quo : quo);
         MD_REM, MD_REMU:
            result_c = div_zero ? a_raw : sovf ? '0 : (neg_r ? -rem : rem);
         default:
            result_c = mul_zero ? '0 : prod_fix[WIDTH-1:0];
      endcase
   end

   // Special cases finish on the second CALC edge, giving a fixed latency
   // of two edges after accept; every other operation runs all WIDTH steps.
   always_comb begin
      last_step = (cnt == CNT_W'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
      if ((div_zero | sovf | mul_zero) && cnt == CNT_W'(1)) last_step = 1'b1;
`else
      last_step = last_step | 1'b0;
`endif
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MD_IDLE;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         MD_IDLE: if (accept) state_nxt = MD_CALC;
         MD_CALC: begin
            if (bus.flush)     state_nxt = MD_IDLE;
            else if (last_step) state_nxt = MD_DONE;
         end
         MD_DONE: if (bus.flush || bus.out_ready) state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.in_ready  = (state == MD_IDLE);
      bus.out_valid = (state == MD_DONE);
      bus.out_data  = out_data_q;
      dbg_state     = state;
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= MD_MUL;
         cnt        <= '0;
         acc        <= '0;
         opnd       <= '0;
         a_raw      <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         div_zero   <= 1'b0;
         sovf       <= 1'b0;
         mul_zero   <= 1'b0;
         out_data_q <= '0;
      end else if (accept) begin
         op_q     <= bus.in_op;
         cnt      <= '0;
         a_raw    <= bus.in_a;
         neg_q    <= a_neg ^ b_neg;
         neg_r    <= a_neg;
         div_zero <= in_is_div & (bus.in_b == '0);
         sovf     <= (bus.in_op == MD_DIV || bus.in_op == MD_REM) &&
                     (bus.in_a == MOST_NEG) && (bus.in_b == '1);
         mul_zero <= ~in_is_div & ((bus.in_a == '0) | (bus.in_b == '0));
         if (in_is_div) begin
            acc  <= {{WIDTH{1'b0}}, a_mag};
            opnd <= b_mag;
         end else begin
            acc  <= {{WIDTH{1'b0}}, b_mag};
            opnd <= a_mag;
         end
      end else if (state == MD_CALC && !bus.flush) begin
         acc <= acc_step;
         cnt <= cnt + CNT_W'(1);
         if (last_step) out_data_q <= result_c;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
   import cpu_pkg::*;

   localparam int W = 32;

   typedef struct packed {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] e;
   } vec_t;

   logic    clk = 1'b0;
   logic    rst_n = 1'b1;
   md_state dbg_state;

   muldiv_unit_if #(.WIDTH(W)) bus ();

   muldiv_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] ref_result(input logic [2:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      longint     sa, sb, ua, ub;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'b0, a};
      ub = {32'b0, b};
      p  = '0;
      case (op)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return '1;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return '1;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] op,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      bit special;
      special = (op[2] && b == 0) ||
                ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
                (!op[2] && (a == 0 || b == 0));
`ifdef MULDIV_EARLY_OUT_EN
      return special ? 2 : W;
`else
      return special ? W : W;
`endif
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      bus.in_valid  = 1'b0;
      bus.in_op     = MD_MUL;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   task automatic start_op(input string name, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_op    = md_op'(op);
      bus.in_a     = a;
      bus.in_b     = b;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s accept_ready: in_ready=%b required=1", name, bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_result(input string name, input int lat_req,
                              output logic [W-1:0] data);
      int lat;
      bit got, ready_seen;
      lat = 0; got = 0; ready_seen = 0;
      while (lat < 100 && !got) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.out_valid === 1'b1) got = 1;
         if (bus.in_ready !== 1'b0) ready_seen = 1;
      end
      data = bus.out_data;
      n_checks++;
      if (!got || lat != lat_req) begin
         n_fail++;
         $display("FAIL %s latency: edges=%0d valid=%b required=%0d", name, lat, got, lat_req);
      end
      n_checks++;
      if (ready_seen) begin
         n_fail++;
         $display("FAIL %s in_ready_busy: in_ready rose while busy, required=0", name);
      end
   endtask

   task automatic take_result(input string name);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s handshake: out_valid=%b in_ready=%b required 0/1",
                  name, bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e);
      logic [W-1:0] got, want;
      exp_q.push_back(e);
      start_op(name, op, a, b);
      wait_result(name, exp_lat(op, a, b), got);
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s data: op=%0d a=%h b=%h out_data=%h required=%h",
                  name, op, a, b, got, want);
      end
      take_result(name);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      drive_idle();
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
          bus.out_data !== '0 || dbg_state !== MD_IDLE) begin
         n_fail++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h state=%0d required 1/0/0/0",
                  bus.in_ready, bus.out_valid, bus.out_data, dbg_state);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      vec_t v[14] = '{
         '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
         '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
         '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
         '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
         '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
         '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
         '{3'd5, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF},
         '{3'd7, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007},
         '{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005},
         '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
         '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
         '{3'd4, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFFF},
         '{3'd0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000},
         '{3'd5, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E}
      };
      for (int i = 0; i < 14; i++)
         run_op($sformatf("directed[%0d]", i), v[i].op, v[i].a, v[i].b, v[i].e);
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return W'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      logic [2:0]   op;
      logic [W-1:0] a, b;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         run_op($sformatf("random[%0d]", i), op, a, b, ref_result(op, a, b));
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]   op;
      logic [W-1:0] a, b, got, want;
      string        nm;
      for (int i = 0; i < 4; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         nm = $sformatf("b2b[%0d]", i);
         exp_q.push_back(ref_result(op, a, b));
         start_op(nm, op, a, b);
         bus.out_ready = 1'b1;
         wait_result(nm, exp_lat(op, a, b), got);
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL %s data: out_data=%h required=%h", nm, got, want);
         end
         @(posedge clk);
         #1;
         n_checks++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s release: out_valid=%b in_ready=%b required 0/1",
                     nm, bus.out_valid, bus.in_ready);
         end
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [W-1:0] got, want;
      want = ref_result(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
      start_op("backpressure", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
      wait_result("backpressure", W, got);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== want || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_hold[%0d]: out_valid=%b out_data=%h in_ready=%b required 1/%h/0",
                     i, bus.out_valid, bus.out_data, bus.in_ready, want);
         end
      end
      take_result("backpressure");
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL backpressure_single: out_valid=%b in_ready=%b required 0/1",
                  bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic watch_no_valid(input string name, input int cycles);
      bit seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid !== 1'b0) seen = 1;
      end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL %s no_result: out_valid=1 seen required=0", name);
      end
   endtask

   task automatic test_flush();
      logic [W-1:0] got;
      // flush on CALC edge 10
      start_op("flush_calc", 3'd5, 32'hDEAD_BEEF, 32'h0000_0013);
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_calc: in_ready=%b out_valid=%b required 1/0",
                  bus.in_ready, bus.out_valid);
      end
      watch_no_valid("flush_calc", 40);
      // flush beats a request in IDLE
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_op    = MD_MUL;
      bus.in_a     = 32'd3;
      bus.in_b     = 32'd4;
      bus.flush    = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      n_checks++;
      if (bus.in_ready !== 1'b1 || dbg_state !== MD_IDLE) begin
         n_fail++;
         $display("FAIL flush_idle: in_ready=%b state=%0d required 1/0", bus.in_ready, dbg_state);
      end
      watch_no_valid("flush_idle", 40);
      // flush in DONE discards the held result
      start_op("flush_done", 3'd0, 32'd9, 32'd9);
      wait_result("flush_done", W, got);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_done: out_valid=%b in_ready=%b required 0/1",
                  bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset_mid();
      run_op("pre_reset", 3'd0, 32'd1000, 32'd1000, 32'd1000000);
      start_op("reset_mid", 3'd4, 32'h7654_3210, 32'h0000_0033);
      repeat (12) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
          bus.out_data !== '0 || dbg_state !== MD_IDLE) begin
         n_fail++;
         $display("FAIL reset_mid: in_ready=%b out_valid=%b out_data=%h state=%0d required 1/0/0/0",
                  bus.in_ready, bus.out_valid, bus.out_data, dbg_state);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_reset", 3'd6, 32'hFFFF_FF9C, 32'h0000_0007,
             ref_result(3'd6, 32'hFFFF_FF9C, 32'h0000_0007));
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
